d_write_buffer: RTL and testbench
=================================

// Module: d_write_buffer
// PURPOSE
//  Posted write buffer between d_cache's uncached single-word store path and the
//  arbitrater's AXI AW/W/B port. Accepts stores in one cycle, retires them to AXI
//  in FIFO order, so an uncached store stalls the M stage only when the buffer is full.
//  Also flags uncached loads that hit a pending store, so d_cache holds the load until drain.
// PARAMETERS
//  DEPTH      4   entries; power of 2, >=2
//  ADDR_W     32  physical address width
// PORTS
//  clk          in   1       system clock (single clock domain)
//  rst          in   1       synchronous, active-high reset
//  wb_valid     in   1       d_cache pushes a store
//  wb_ready     out  1       = ~full; push accepted when wb_valid & wb_ready
//  wb_addr      in   32      physical byte address
//  wb_size      in   3       AXI size (0 byte, 1 half, 2 word)
//  wb_strb      in   4       byte strobes
//  wb_data      in   32      store data, lane-aligned
//  wb_empty     out  1       no entries and drain FSM idle
//  q_addr       in   32      uncached load address from d_cache
//  q_conflict   out  1       q_addr[31:2] matches any valid entry (incl. in-flight head)
//  awaddr       out  32      to arbitrater d_awaddr
//  awlen        out  4       constant 0
//  awsize       out  3       head entry size
//  awvalid      out  1
//  awready      in   1
//  wdata        out  32
//  wstrb        out  4
//  wlast        out  1       constant 1
//  wvalid       out  1
//  wready       in   1
//  bvalid       in   1
//  bready       out  1
// BEHAVIOUR
//  Reset: count=0, rd/wr ptr=0, state IDLE; awvalid=wvalid=bready=0, wb_ready=1,
//   wb_empty=1, q_conflict=0. awaddr/wdata/wstrb/awsize reset to 0.
//  FIFO: pointers log2(DEPTH) bits, wrap naturally; count 0..DEPTH.
//   wb_ready derived from registered count only: full buffer rejects push even in
//   a pop cycle (no same-cycle bypass). Push+pop same cycle: count unchanged.
//  Drain FSM (head = entry at rd ptr):
//   IDLE : count!=0 -> SEND; load head into AW/W regs, awvalid=wvalid=1 next cycle.
//   SEND : awvalid drops on awready, wvalid drops on wready, independently (either
//          order or same cycle). Both done -> RESP, bready=1.
//   RESP : on bvalid: bready=0, pop head (rd ptr++, count--), -> IDLE.
//  Latency: push into empty idle buffer -> awvalid high 2 cycles later; min 4 cycles
//   per store with zero-wait AXI. Head not popped before B, so q_conflict holds
//   until write response (guarantees load-after-store ordering to device).
//  AW/W payload stable while valid; awvalid/wvalid never deasserted before handshake.
//  bresp ignored (no bus-error exception). One outstanding AXI write max.
//  q_conflict combinational: OR over valid entries of addr[31:2]==q_addr[31:2];
//   a push this cycle is not visible until next cycle.
//  wb_empty = (count==0) & (state==IDLE).
//  Reset mid-transaction: all entries discarded, FSM to IDLE; AXI slave is reset
//   by the same rst.
// STRUCTURE
//  Shared package: AXI constants (BURST_INCR 2'b01, SIZE_BYTE/HALF/WORD, LEN_SINGLE)
//   and drain FSM state encoding typedef.
//  One sub-module: wb_fifo (storage, ptrs, count, parallel addr compare);
//   drain FSM + AXI regs in d_write_buffer.
// TESTING
//  1 push {0x1FAF_0000,w,f,0x12345678}, awready=wready=bvalid same-cycle ready ->
//    AW/W seen 2 cycles after push, wb_empty=1 4 cycles after push.
//  2 4 pushes back-to-back, awready held 0 -> wb_ready=0 after 4th, 5th push
//    stalled; release -> 4 writes in push order, addrs/data match.
//  3 wready 3 cycles before awready -> wvalid drops first, awvalid held, single B,
//    one pop; payload stable throughout.
//  4 pending store 0x1FAF_F004, q_addr=0x1FAF_F006 -> q_conflict=1 until bvalid
//    cycle+1, then 0; q_addr=0x1FAF_F008 -> 0.
//  5 full buffer, push during B-pop cycle -> rejected; next cycle accepted, count=4.
//  6 rst asserted in SEND with 3 entries -> next cycle awvalid=0, wb_empty=1.

Source files
------------

// File: rtl/d_write_buffer_pkg.sv
// Shared AXI constants and drain FSM encoding for the uncached-store posted write buffer.
package d_write_buffer_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_BYTE  = 3'b000;
  localparam logic [2:0] SIZE_HALF  = 3'b001;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [3:0] LEN_SINGLE = 4'b0000;

  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int SIZE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_RESP = 2'b10
  } drain_state_e;

endpackage

// File: rtl/d_write_buffer_fifo.sv
// Store FIFO for the write buffer: payload storage, pointers, occupancy and a
// parallel word-address compare of every valid entry against the uncached load address.
module wb_fifo
  import d_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [ADDR_W-1:0]            push_addr,
  input  logic [SIZE_W-1:0]            push_size,
  input  logic [STRB_W-1:0]            push_strb,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [ADDR_W-1:0]            head_addr,
  output logic [SIZE_W-1:0]            head_size,
  output logic [STRB_W-1:0]            head_strb,
  output logic [DATA_W-1:0]            head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  input  logic [ADDR_W-1:0]            q_addr,
  output logic                         q_conflict
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [DEPTH-1:0]  valid_r;
  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [SIZE_W-1:0] size_mem_r [DEPTH];
  logic [STRB_W-1:0] strb_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic              conflict_s;
  logic              unused_q_lsb_s;

  // Pointer, occupancy and per-entry valid bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      valid_r  <= DEPTH'(0);
    end else begin
      if (push) begin
        wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
        valid_r[wr_ptr_r]  <= 1'b1;
      end
      if (pop) begin
        rd_ptr_r           <= rd_ptr_r + PTR_W'(1);
        valid_r[rd_ptr_r]  <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage; contents are only meaningful where valid_r is set
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_r[wr_ptr_r] <= push_addr;
      size_mem_r[wr_ptr_r] <= push_size;
      strb_mem_r[wr_ptr_r] <= push_strb;
      data_mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Word-granular hit check; the head stays valid until its write response
  always_comb begin
    conflict_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      conflict_s = conflict_s |
                   (valid_r[i] & (addr_mem_r[i][ADDR_W-1:2] == q_addr[ADDR_W-1:2]));
    end
  end

  assign unused_q_lsb_s = ^q_addr[1:0];
  assign q_conflict     = conflict_s;
  assign head_addr      = addr_mem_r[rd_ptr_r];
  assign head_size      = size_mem_r[rd_ptr_r];
  assign head_strb      = strb_mem_r[rd_ptr_r];
  assign head_data      = data_mem_r[rd_ptr_r];
  assign count          = count_r;
  assign full           = (count_r == CNT_W'(DEPTH));

endmodule

// File: rtl/d_write_buffer.sv
// Posted write buffer for uncached single-word stores: queues stores from d_cache
// and retires them one at a time to the AXI AW/W/B port in FIFO order.
module d_write_buffer
  import d_write_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [2:0]        wb_size,
  input  logic [3:0]        wb_strb,
  input  logic [31:0]       wb_data,
  output logic              wb_empty,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_conflict,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready
);

  localparam int CNT_W = $clog2(DEPTH+1);

  drain_state_e      state_r;
  drain_state_e      next_state_s;
  logic [CNT_W-1:0]  count_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              load_s;
  logic              aw_done_s;
  logic              w_done_s;
  logic [ADDR_W-1:0] head_addr_s;
  logic [SIZE_W-1:0] head_size_s;
  logic [STRB_W-1:0] head_strb_s;
  logic [DATA_W-1:0] head_data_s;
  logic [ADDR_W-1:0] awaddr_r;
  logic [2:0]        awsize_r;
  logic              awvalid_r;
  logic [31:0]       wdata_r;
  logic [3:0]        wstrb_r;
  logic              wvalid_r;
  logic              bready_r;

  assign push_s = wb_valid & ~full_s;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_addr  (wb_addr),
    .push_size  (wb_size),
    .push_strb  (wb_strb),
    .push_data  (wb_data),
    .pop        (pop_s),
    .head_addr  (head_addr_s),
    .head_size  (head_size_s),
    .head_strb  (head_strb_s),
    .head_data  (head_data_s),
    .count      (count_s),
    .full       (full_s),
    .q_addr     (q_addr),
    .q_conflict (q_conflict)
  );

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // An AXI channel is finished once its valid is low or is being accepted now
  assign aw_done_s = ~awvalid_r | awready;
  assign w_done_s  = ~wvalid_r | wready;

  // Drain FSM next-state
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (count_s != CNT_W'(0)) next_state_s = ST_SEND;
        else                      next_state_s = ST_IDLE;
      end
      ST_SEND: begin
        if (aw_done_s & w_done_s) next_state_s = ST_RESP;
        else                      next_state_s = ST_SEND;
      end
      ST_RESP: begin
        if (bvalid) next_state_s = ST_IDLE;
        else        next_state_s = ST_RESP;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Drain FSM decoded actions
  always_comb begin
    load_s = 1'b0;
    pop_s  = 1'b0;
    case (state_r)
      ST_IDLE: load_s = (count_s != CNT_W'(0));
      ST_SEND: load_s = 1'b0;
      ST_RESP: pop_s  = bvalid;
      default: begin
        load_s = 1'b0;
        pop_s  = 1'b0;
      end
    endcase
  end

  // AXI request/response registers; payload only changes on a new head load
  always_ff @(posedge clk) begin
    if (rst) begin
      awaddr_r  <= ADDR_W'(0);
      awsize_r  <= 3'b000;
      awvalid_r <= 1'b0;
      wdata_r   <= 32'h0000_0000;
      wstrb_r   <= 4'b0000;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
    end else begin
      if (load_s) begin
        awaddr_r  <= head_addr_s;
        awsize_r  <= head_size_s;
        wdata_r   <= head_data_s;
        wstrb_r   <= head_strb_s;
        awvalid_r <= 1'b1;
        wvalid_r  <= 1'b1;
      end else begin
        if (awvalid_r & awready) awvalid_r <= 1'b0;
        if (wvalid_r & wready)   wvalid_r  <= 1'b0;
      end
      if ((state_r == ST_SEND) && (next_state_s == ST_RESP)) bready_r <= 1'b1;
      else if (pop_s)                                       bready_r <= 1'b0;
    end
  end

  assign wb_ready = ~full_s;
  assign wb_empty = (count_s == CNT_W'(0)) && (state_r == ST_IDLE);
  assign awaddr   = awaddr_r;
  assign awlen    = LEN_SINGLE;
  assign awsize   = awsize_r;
  assign awvalid  = awvalid_r;
  assign wdata    = wdata_r;
  assign wstrb    = wstrb_r;
  assign wlast    = 1'b1;
  assign wvalid   = wvalid_r;
  assign bready   = bready_r;

endmodule

// File: tb/tb_d_write_buffer.sv
// Randomized bench for d_write_buffer, checked against a queue-based model of
// pending stores plus directed latency, stall, conflict and reset scenarios.
module tb_d_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_addr;
  logic [2:0]  wb_size;
  logic [3:0]  wb_strb;
  logic [31:0] wb_data;
  logic        wb_empty;
  logic [31:0] q_addr;
  logic        q_conflict;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  always #5 clk = ~clk;

  d_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_size(wb_size),
    .wb_strb(wb_strb), .wb_data(wb_data), .wb_empty(wb_empty),
    .q_addr(q_addr), .q_conflict(q_conflict),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strb;
    logic [31:0] data;
  } ent_t;

  // Model: stores accepted but not yet acknowledged on B, oldest first
  ent_t pend_q[$];
  bit   aw_done, w_done, aw_hold, w_hold;
  int   n_b = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_conflict(input logic [31:0] a);
    bit hit = 1'b0;
    foreach (pend_q[i]) if (pend_q[i].addr[31:2] == a[31:2]) hit = 1'b1;
    return hit;
  endfunction

  task automatic check_outputs();
    check("wb_ready", 32'(wb_ready), 32'(pend_q.size() < DEPTH));
    check("wb_empty", 32'(wb_empty), 32'(pend_q.size() == 0));
    check("q_conflict", 32'(q_conflict), 32'(model_conflict(q_addr)));
    check("awlen", 32'(awlen), 32'd0);
    check("wlast", 32'(wlast), 32'd1);
    if (aw_hold) check("aw_hold", 32'(awvalid), 32'd1);
    if (w_hold)  check("w_hold", 32'(wvalid), 32'd1);
    if (awvalid) begin
      check("aw_legal", 32'(pend_q.size() != 0 && !aw_done), 32'd1);
      if (pend_q.size() != 0) begin
        check("awaddr", awaddr, pend_q[0].addr);
        check("awsize", 32'(awsize), 32'(pend_q[0].size));
      end
    end
    if (wvalid) begin
      check("w_legal", 32'(pend_q.size() != 0 && !w_done), 32'd1);
      if (pend_q.size() != 0) begin
        check("wdata", wdata, pend_q[0].data);
        check("wstrb", 32'(wstrb), 32'(pend_q[0].strb));
      end
    end
    if (bready) check("b_legal", 32'(aw_done && w_done), 32'd1);
  endtask

  // Called at a negedge with inputs set: check, advance the model over the next edge
  task automatic tick();
    bit   m_ready;
    ent_t e;
    #1;
    check_outputs();
    m_ready = (pend_q.size() < DEPTH);
    if (rst) begin
      pend_q.delete();
      aw_done = 1'b0; w_done = 1'b0; aw_hold = 1'b0; w_hold = 1'b0;
    end else begin
      aw_hold = awvalid && !awready;
      w_hold  = wvalid && !wready;
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready)   w_done  = 1'b1;
      if (bvalid && bready) begin
        pend_q.delete(0);
        aw_done = 1'b0; w_done = 1'b0;
        n_b++;
      end
      if (wb_valid && m_ready) begin
        e.addr = wb_addr; e.size = wb_size; e.strb = wb_strb; e.data = wb_data;
        pend_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive_push(input logic [31:0] a, input logic [2:0] s,
                            input logic [3:0] st, input logic [31:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_size = s; wb_strb = st; wb_data = d;
  endtask

  task automatic drain(input string tag);
    wb_valid = 1'b0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    for (int k = 0; k < 200 && pend_q.size() != 0; k++) tick();
    check({tag, "_drained"}, 32'(pend_q.size()), 32'd0);
    #1;
    check({tag, "_empty"}, 32'(wb_empty), 32'd1);
  endtask

  task automatic wait_awvalid(input string tag);
    for (int k = 0; k < 20 && !awvalid; k++) tick();
    check({tag, "_aw_seen"}, 32'(awvalid), 32'd1);
  endtask

  task automatic wait_bready(input string tag);
    for (int k = 0; k < 20 && !bready; k++) tick();
    check({tag, "_b_seen"}, 32'(bready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    rst = 1'b1; wb_valid = 1'b0; wb_addr = 32'h0; wb_size = 3'd0; wb_strb = 4'h0;
    wb_data = 32'h0; q_addr = 32'h0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid", 32'(wvalid), 32'd0);
    check("rst_bready", 32'(bready), 32'd0);
    check("rst_wb_ready", 32'(wb_ready), 32'd1);
    check("rst_wb_empty", 32'(wb_empty), 32'd1);
    check("rst_q_conflict", 32'(q_conflict), 32'd0);
    check("rst_awaddr", awaddr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_wstrb", 32'(wstrb), 32'd0);
    check("rst_awsize", 32'(awsize), 32'd0);

    // 1: single store latency with zero-wait slave
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    drive_push(32'h1FAF_0000, 3'd2, 4'hF, 32'h1234_5678);
    tick();
    wb_valid = 1'b0;
    #1 check("t1_aw_c1", 32'(awvalid), 32'd0);
    tick();
    #1 check("t1_aw_c2", 32'(awvalid), 32'd1);
    check("t1_w_c2", 32'(wvalid), 32'd1);
    check("t1_awaddr", awaddr, 32'h1FAF_0000);
    check("t1_wdata", wdata, 32'h1234_5678);
    tick();
    #1 check("t1_bready_c3", 32'(bready), 32'd1);
    check("t1_empty_c3", 32'(wb_empty), 32'd0);
    tick();
    #1 check("t1_empty_c4", 32'(wb_empty), 32'd1);

    // 2: fill while AW is blocked, fifth push stalls, then ordered drain
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
    b0 = n_b;
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h2000_0000 + 32'(i * 16), 3'd2, 4'hF, $urandom);
      tick();
    end
    drive_push(32'h2000_0100, 3'd2, 4'hF, 32'hDEAD_BEEF);
    #1 check("t2_full", 32'(wb_ready), 32'd0);
    repeat (3) tick();
    check("t2_stalled", 32'(wb_ready), 32'd0);
    drain("t2");
    check("t2_nwrites", 32'(n_b - b0), 32'd4);

    // 3: W accepted three cycles before AW
    awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
    b0 = n_b;
    drive_push(32'h1FAF_1000, 3'd1, 4'h3, 32'h0000_ABCD);
    tick();
    wb_valid = 1'b0;
    wait_awvalid("t3");
    tick();
    for (int i = 0; i < 3; i++) begin
      #1 check("t3_w_drop", 32'(wvalid), 32'd0);
      check("t3_aw_held", 32'(awvalid), 32'd1);
      tick();
    end
    drain("t3");
    check("t3_nwrites", 32'(n_b - b0), 32'd1);

    // 4: load conflict held until the B handshake
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    q_addr = 32'h1FAF_F006;
    drive_push(32'h1FAF_F004, 3'd2, 4'hF, 32'hCAFE_F00D);
    tick();
    wb_valid = 1'b0;
    wait_bready("t4");
    check("t4_conf_pend", 32'(q_conflict), 32'd1);
    q_addr = 32'h1FAF_F008;
    #1 check("t4_conf_other", 32'(q_conflict), 32'd0);
    q_addr = 32'h1FAF_F006;
    tick();
    bvalid = 1'b1;
    #1 check("t4_conf_bcycle", 32'(q_conflict), 32'd1);
    tick();
    bvalid = 1'b0;
    #1 check("t4_conf_after", 32'(q_conflict), 32'd0);

    // 5: push in the B-pop cycle of a full buffer is refused, accepted next cycle
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(32'h4000_0000 + 32'(i * 4), 3'd2, 4'hF, $urandom);
      tick();
    end
    wb_valid = 1'b0;
    wait_bready("t5");
    bvalid = 1'b1;
    drive_push(32'h4000_0100, 3'd0, 4'h1, 32'h0000_0055);
    #1 check("t5_reject", 32'(wb_ready), 32'd0);
    tick();
    bvalid = 1'b0;
    #1 check("t5_ready_next", 32'(wb_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    #1 check("t5_full_again", 32'(wb_ready), 32'd0);
    drain("t5");

    // 6: reset while sending with three entries queued
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(32'h5000_0000 + 32'(i * 4), 3'd2, 4'hF, $urandom);
      tick();
    end
    wb_valid = 1'b0;
    wait_awvalid("t6");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1 check("t6_awvalid", 32'(awvalid), 32'd0);
    check("t6_wvalid", 32'(wvalid), 32'd0);
    check("t6_empty", 32'(wb_empty), 32'd1);

    // Random traffic over a small address pool to exercise conflicts and back-pressure
    for (int c = 0; c < 800; c++) begin
      wb_valid = ($urandom_range(0, 99) < 45);
      wb_addr  = 32'h3000_0000 | (32'($urandom_range(0, 5)) << 2) | 32'($urandom_range(0, 3));
      wb_size  = 3'($urandom_range(0, 2));
      wb_strb  = 4'($urandom_range(0, 15));
      wb_data  = $urandom;
      q_addr   = 32'h3000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      awready  = ($urandom_range(0, 99) < 60);
      wready   = ($urandom_range(0, 99) < 60);
      bvalid   = ($urandom_range(0, 99) < 50);
      tick();
    end
    drain("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
